// File: rtl/memory_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage, bundled as one port.
// master drives the EX/MEM side; slave is the memory stage itself.
interface memory_stage_if #(
    parameter int unsigned M = 32,
    parameter int unsigned N = 5
);
    logic         validM;
    logic [M-1:0] aluM;
    logic [M-1:0] writeDM;
    logic [N-1:0] writeRM;
    logic [M-1:0] pcplusM;
    logic         memreadM;
    logic         memwriteM;
    logic         regwriteM;
    logic         jalM;
    logic         stallM;
    logic [M-1:0] resultW;
    logic [N-1:0] writeRW;
    logic         regwriteW;
    logic         validW;
    logic         memerr;

    modport master (
        output validM, aluM, writeDM, writeRM, pcplusM, memreadM, memwriteM, regwriteM, jalM,
        input  stallM, resultW, writeRW, regwriteW, validW, memerr
    );

    modport slave (
        input  validM, aluM, writeDM, writeRM, pcplusM, memreadM, memwriteM, regwriteM, jalM,
        output stallM, resultW, writeRW, regwriteW, validW, memerr
    );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: word-addressed synchronous RAM access and MEM/WB register.
// Loads spend one extra cycle in StLoadWait while upstream is stalled.
module memory_stage #(
    parameter int unsigned M = 32,
    parameter int unsigned N = 5,
    parameter int unsigned A = 10
) (
    input logic          CLK,
    input logic          RSTN,
    memory_stage_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StLoadWait} state_e;

    state_e       state_q, state_d;
    logic [M-1:0] result_q, result_d;
    logic [N-1:0] writer_q, writer_d;
    logic         regwrite_q, regwrite_d;
    logic         valid_q, valid_d;
    logic         memerr_q, memerr_d;
    logic         rd_ok_q, rd_ok_d;
    logic         stall;

    logic [M-1:0] mem [2**A];
    logic [M-1:0] rdata_q;

    logic [A-1:0] addr;
    logic         in_range;
    logic         is_store;
    logic         is_load;
    logic         do_write;

    assign addr     = bus.aluM[A-1:0];
    assign in_range = (bus.aluM[M-1:A] == '0);
    // A simultaneous read+write request is a store.
    assign is_store = bus.validM & bus.memwriteM;
    assign is_load  = bus.validM & bus.memreadM & ~bus.memwriteM;
    assign do_write = RSTN & (state_q == StIdle) & is_store & in_range;

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        writer_d   = writer_q;
        regwrite_d = regwrite_q;
        valid_d    = valid_q;
        rd_ok_d    = rd_ok_q;
        stall      = 1'b0;
        memerr_d   = memerr_q;
        case (state_q)
            StIdle: begin
                memerr_d = memerr_q |
                           (bus.validM & (bus.memreadM | bus.memwriteM) & ~in_range);
                if (is_load) begin
                    stall      = 1'b1;
                    valid_d    = 1'b0;
                    regwrite_d = 1'b0;
                    rd_ok_d    = in_range;
                    state_d    = StLoadWait;
                end else begin
                    result_d   = bus.jalM ? bus.pcplusM : bus.aluM;
                    writer_d   = bus.writeRM;
                    regwrite_d = bus.regwriteM & bus.validM;
                    valid_d    = bus.validM;
                    state_d    = StIdle;
                end
            end
            StLoadWait: begin
                result_d   = rd_ok_q ? rdata_q : '0;
                writer_d   = bus.writeRM;
                regwrite_d = bus.regwriteM & bus.validM;
                valid_d    = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q    <= StIdle;
            result_q   <= '0;
            writer_q   <= '0;
            regwrite_q <= 1'b0;
            valid_q    <= 1'b0;
            memerr_q   <= 1'b0;
            rd_ok_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            writer_q   <= writer_d;
            regwrite_q <= regwrite_d;
            valid_q    <= valid_d;
            memerr_q   <= memerr_d;
            rd_ok_q    <= rd_ok_d;
        end
    end

    // RAM is deliberately not reset; read data is consumed only in StLoadWait.
    always_ff @(posedge CLK) begin
        if (do_write) begin
            mem[addr] <= bus.writeDM;
        end
        rdata_q <= mem[addr];
    end

    assign bus.stallM    = RSTN & stall;
    assign bus.resultW   = result_q;
    assign bus.writeRW   = writer_q;
    assign bus.regwriteW = regwrite_q;
    assign bus.validW    = valid_q;
    assign bus.memerr    = memerr_q;

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory stage of the pipelined processor. It consumes the EX/MEM register outputs (ALU result, store data, destination register, PC+1) and the matching control bits. It performs the data-memory access against an internal word-addressed synchronous RAM and registers the selected result into the MEM/WB boundary. Loads take two cycles; the block stalls upstream stages for the extra cycle.

## Interface
Parameters:
- M, 32, data/address width
- N, 5, register-index width
- A, 10, RAM address bits (depth 2^A words)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RSTN  in  1  synchronous active-low reset
- validM  in  1  instruction present in MEM
- aluM  in  M  ALU result; the word address for loads and stores
- writeDM  in  M  store data
- writeRM  in  N  destination register
- pcplusM  in  M  PC+1 of the instruction
- memreadM  in  1  load
- memwriteM  in  1  store
- regwriteM  in  1  instruction writes the register file
- jalM  in  1  result is pcplusM
- stallM  out  1  combinational; holds IF/ID/EX/EX-MEM registers this cycle
- resultW  out  M  registered result: jal ? pcplus : (load ? rdata : alu)
- writeRW  out  N  registered destination
- regwriteW  out  1  registered write enable, qualified by validW
- validW  out  1  registered valid
- memerr  out  1  sticky out-of-range access flag

## Operation
- Address: addr = aluM[A-1:0]. The access is in range when aluM[M-1:A] == 0.
- FSM states: IDLE, LOADWAIT. Reset state is IDLE.
- IDLE, no valid memory op: the MEM/WB register captures the inputs and resultW is computed from jalM and aluM. Next state is IDLE.
- IDLE, validM & memwriteM: the RAM write happens on this edge if the address is in range. MEM/WB captures the inputs with resultW = jalM ? pcplusM : aluM. Stores never stall.
- memreadM & memwriteM together: treated as a store and memreadM is ignored. This is not an error.
- IDLE, validM & memreadM & ~memwriteM: stallM = 1. The RAM read is issued at addr. MEM/WB loads a bubble (validW = 0, regwriteW = 0, resultW and writeRW hold their previous values). Next state is LOADWAIT.
- LOADWAIT: stallM = 0. Upstream held its inputs, so the same load is still presented. MEM/WB captures resultW = RAM data (0 if out of range), writeRW = writeRM, regwriteW = regwriteM, validW = 1. Next state is IDLE.
- Out-of-range access: a store is suppressed and a load returns 0. memerr is set the cycle after the access and stays set until reset.
- regwriteW = regwriteM & validM at capture.
- RAM contents are not cleared by reset and are undefined until written.

## Timing
- Reset (RSTN = 0 at an edge): state = IDLE; resultW = 0, writeRW = 0, regwriteW = 0, validW = 0, memerr = 0. stallM is forced to 0 while RSTN = 0. No RAM write occurs during reset.
- Reset during LOADWAIT drops the pending load, and no writeback occurs.
- Latency presented→WB: 1 cycle for non-loads, 2 cycles for loads.
- Exactly one stall cycle per load. Back-to-back loads produce the pattern stall, no-stall, stall, no-stall, …
- Store followed directly by a load to the same address: the load returns the new data, because the write edge precedes the read edge.
- stallM depends only on state, validM, memreadM, memwriteM and RSTN. It has no path from RAM data.
- pcplusM wraps naturally at 2^M. No arithmetic is done in this block.

## Test plan
- Reset: hold RSTN = 0 for 2 cycles with memreadM = 1 → stallM = 0, all outputs 0, state IDLE.
- ALU op: aluM = 0x1234, writeRM = 7, regwriteM = 1 → next cycle resultW = 0x1234, writeRW = 7, regwriteW = 1, validW = 1.
- Store then load: store 0xDEADBEEF to addr 5, then load addr 5 to reg 3 → stallM high for one cycle, bubble in WB, then resultW = 0xDEADBEEF, writeRW = 3, regwriteW = 1.
- jal: jalM = 1, pcplusM = 0x40, writeRM = 31 → resultW = 0x40, writeRW = 31.
- Out of range: store to aluM = 0x400 (A = 10) → RAM unchanged (load addr 0 returns its prior value), memerr = 1 and stays 1. A load at 0x400 returns 0.
- Reset in LOADWAIT: issue a load, assert RSTN = 0 in the next cycle → validW = 0, regwriteW = 0, state IDLE, and no writeback of the load.
